// File: rtl/matmul_job_scheduler.sv
// Job FIFO and launch sequencer for systolic_array_top: queues descriptors, launches one at a time, reports tagged completions.
// Optional watchdog: define MATMUL_JOB_TIMEOUT_EN to enable the RUN timeout (status TIMEOUT).
module matmul_job_scheduler #(
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DIM_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_valid_i,
  output logic                          push_ready_o,
  input  logic [ADDR_WIDTH-1:0]         push_a_addr_i,
  input  logic [ADDR_WIDTH-1:0]         push_b_addr_i,
  input  logic [ADDR_WIDTH-1:0]         push_c_addr_i,
  input  logic [DIM_WIDTH-1:0]          push_m_i,
  input  logic [DIM_WIDTH-1:0]          push_n_i,
  input  logic [DIM_WIDTH-1:0]          push_p_i,
  output logic [3:0]                    push_id_o,
  output logic                          start_o,
  output logic [ADDR_WIDTH-1:0]         base_addr_a_o,
  output logic [ADDR_WIDTH-1:0]         base_addr_b_o,
  output logic [ADDR_WIDTH-1:0]         base_addr_c_o,
  output logic [DIM_WIDTH-1:0]          m_o,
  output logic [DIM_WIDTH-1:0]          n_o,
  output logic [DIM_WIDTH-1:0]          p_o,
  input  logic                          done_i,
  output logic                          cmpl_valid_o,
  input  logic                          cmpl_ready_i,
  output logic [3:0]                    cmpl_id_o,
  output logic [1:0]                    cmpl_status_o,
  output logic                          busy_o,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_level_o
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ID_W  = 4;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BAD_DIM = 2'd1;
`ifdef MATMUL_JOB_TIMEOUT_EN
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("matmul_job_scheduler: QUEUE_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES nonzero");
  end

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DIM_WIDTH-1:0]  m;
    logic [DIM_WIDTH-1:0]  n;
    logic [DIM_WIDTH-1:0]  p;
    logic [ID_W-1:0]       id;
  } job_t;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPORT} state_t;

  state_t           state;
  job_t             mem [QUEUE_DEPTH];
  job_t             head;
  job_t             push_job;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] level_next;
  logic [ID_W-1:0]  id_cnt;
  logic             push_fire;
  logic             pop_fire;
  logic             head_bad;
`ifdef MATMUL_JOB_TIMEOUT_EN
  logic [TO_W-1:0]  run_cnt;
`endif

  assign push_fire     = push_valid_i & push_ready_o;
  assign pop_fire      = (state == IDLE) & (level != '0);
  assign head          = mem[rd_ptr];
  assign head_bad      = (head.m == '0) | (head.n == '0) | (head.p == '0);
  assign push_id_o     = id_cnt;
  assign queue_level_o = level;

  always_comb begin
    push_job        = '0;
    push_job.a_addr = push_a_addr_i;
    push_job.b_addr = push_b_addr_i;
    push_job.c_addr = push_c_addr_i;
    push_job.m      = push_m_i;
    push_job.n      = push_n_i;
    push_job.p      = push_p_i;
    push_job.id     = id_cnt;
  end

  // Occupancy: a same-cycle push and pop nets to zero.
  always_comb begin
    level_next = level;
    if (push_fire && !pop_fire) begin
      level_next = level + LVL_W'(1);
    end else if (pop_fire && !push_fire) begin
      level_next = level - LVL_W'(1);
    end
  end

  // FIFO pointers, level, ready flag and job ID counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      push_ready_o <= 1'b1;
      id_cnt       <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        id_cnt <= id_cnt + ID_W'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level        <= level_next;
      push_ready_o <= (level_next != LVL_W'(QUEUE_DEPTH));
    end
  end

  // Storage needs no reset; the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr] <= push_job;
    end
  end

  // Launch sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      start_o       <= 1'b0;
      busy_o        <= 1'b0;
      cmpl_valid_o  <= 1'b0;
      cmpl_id_o     <= '0;
      cmpl_status_o <= ST_OK;
      base_addr_a_o <= '0;
      base_addr_b_o <= '0;
      base_addr_c_o <= '0;
      m_o           <= '0;
      n_o           <= '0;
      p_o           <= '0;
`ifdef MATMUL_JOB_TIMEOUT_EN
      run_cnt       <= '0;
`endif
    end else begin
      start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pop_fire) begin
            busy_o    <= 1'b1;
            cmpl_id_o <= head.id;
            if (head_bad) begin
              cmpl_status_o <= ST_BAD_DIM;
              cmpl_valid_o  <= 1'b1;
              state         <= REPORT;
            end else begin
              base_addr_a_o <= head.a_addr;
              base_addr_b_o <= head.b_addr;
              base_addr_c_o <= head.c_addr;
              m_o           <= head.m;
              n_o           <= head.n;
              p_o           <= head.p;
              start_o       <= 1'b1;
              state         <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          state <= RUN;
`ifdef MATMUL_JOB_TIMEOUT_EN
          run_cnt <= '0;
`endif
        end
        RUN: begin
          if (done_i) begin
            cmpl_status_o <= ST_OK;
            cmpl_valid_o  <= 1'b1;
            state         <= REPORT;
          end
`ifdef MATMUL_JOB_TIMEOUT_EN
          else if (run_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            cmpl_status_o <= ST_TIMEOUT;
            cmpl_valid_o  <= 1'b1;
            state         <= REPORT;
          end else begin
            run_cnt <= run_cnt + TO_W'(1);
          end
`endif
        end
        REPORT: begin
          if (cmpl_ready_i) begin
            cmpl_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Scoreboard bench for matmul_job_scheduler: expected completions queued at push, checked at launch and completion.
module tb_matmul_job_scheduler;

  localparam int unsigned QD = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 50;

  logic          clk = 1'b0;
  logic          reset;
  logic          push_valid_i;
  logic          push_ready_o;
  logic [AW-1:0] push_a_addr_i, push_b_addr_i, push_c_addr_i;
  logic [DW-1:0] push_m_i, push_n_i, push_p_i;
  logic [3:0]    push_id_o;
  logic          start_o;
  logic [AW-1:0] base_addr_a_o, base_addr_b_o, base_addr_c_o;
  logic [DW-1:0] m_o, n_o, p_o;
  logic          done_i;
  logic          cmpl_valid_o;
  logic          cmpl_ready_i;
  logic [3:0]    cmpl_id_o;
  logic [1:0]    cmpl_status_o;
  logic          busy_o;
  logic [2:0]    queue_level_o;
  logic [95:0]   dut_desc;

  always #5 clk = ~clk;

  matmul_job_scheduler #(
    .QUEUE_DEPTH(QD), .ADDR_WIDTH(AW), .DIM_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_a_addr_i(push_a_addr_i), .push_b_addr_i(push_b_addr_i), .push_c_addr_i(push_c_addr_i),
    .push_m_i(push_m_i), .push_n_i(push_n_i), .push_p_i(push_p_i),
    .push_id_o(push_id_o), .start_o(start_o),
    .base_addr_a_o(base_addr_a_o), .base_addr_b_o(base_addr_b_o), .base_addr_c_o(base_addr_c_o),
    .m_o(m_o), .n_o(n_o), .p_o(p_o),
    .done_i(done_i), .cmpl_valid_o(cmpl_valid_o), .cmpl_ready_i(cmpl_ready_i),
    .cmpl_id_o(cmpl_id_o), .cmpl_status_o(cmpl_status_o),
    .busy_o(busy_o), .queue_level_o(queue_level_o)
  );

  assign dut_desc = {base_addr_a_o, base_addr_b_o, base_addr_c_o, m_o, n_o, p_o};

  typedef struct {
    logic [3:0]  id;
    logic [1:0]  status;
    logic [95:0] desc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [3:0]  model_id;
  logic [95:0] last_desc;
  logic        prev_start;
  int          last_start_cyc;
  bit          have_last_start;
  bit          done_en;
  int          done_delay;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Launch and completion monitor.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_start      = 1'b0;
      have_last_start = 1'b0;
      last_desc       = '0;
    end else begin
      if (start_o) begin
        check("start_width", prev_start, 1'b0);
        if (have_last_start) check("start_gap", (cyc - last_start_cyc) >= 3, 1'b1);
        last_start_cyc  = cyc;
        have_last_start = 1'b1;
        if (exp_q.size() == 0) begin
          check("start_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q[0];
          check("start_dims_ok", e.status != 2'd1, 1'b1);
          check("start_desc", dut_desc, e.desc);
          last_desc = e.desc;
        end
      end
      prev_start = start_o;
      if (cmpl_valid_o && cmpl_ready_i) begin
        if (exp_q.size() == 0) begin
          check("cmpl_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("cmpl_id", cmpl_id_o, e.id);
          check("cmpl_status", cmpl_status_o, e.status);
          if (e.status == 2'd1) check("bad_dim_desc_hold", dut_desc, last_desc);
        end
      end
    end
  end

  // Array model: pulses done a programmable delay after each launch.
  initial begin
    done_i = 1'b0;
    forever begin
      @(negedge clk);
      if (start_o && done_en && !reset) begin
        repeat (done_delay) @(negedge clk);
        if (done_en) begin
          done_i = 1'b1;
          @(negedge clk);
          done_i = 1'b0;
        end
      end
    end
  end

  task automatic push_job(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                          input logic [15:0] m, input logic [15:0] n, input logic [15:0] p,
                          input bit timeout_job);
    exp_t e;
    int   k;
    @(negedge clk);
    push_a_addr_i = a; push_b_addr_i = b; push_c_addr_i = c;
    push_m_i = m; push_n_i = n; push_p_i = p;
    push_valid_i = 1'b1;
    k = 0;
    while (!push_ready_o && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!push_ready_o) begin
      check("push_ready_timeout", 1'b0, 1'b1);
      push_valid_i = 1'b0;
    end else begin
      check("push_id", push_id_o, model_id);
      @(posedge clk);
      e.id     = model_id;
      e.status = (m == 16'd0 || n == 16'd0 || p == 16'd0) ? 2'd1 : (timeout_job ? 2'd2 : 2'd0);
      e.desc   = {a, b, c, m, n, p};
      exp_q.push_back(e);
      model_id = model_id + 4'd1;
      @(negedge clk);
      push_valid_i = 1'b0;
    end
  endtask

  task automatic wait_start(output int at_cyc);
    int k = 0;
    while (!start_o && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("start_seen", start_o, 1'b1);
    at_cyc = cyc;
  endtask

  task automatic wait_cmpl(output int at_cyc);
    int k = 0;
    while (!cmpl_valid_o && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("cmpl_seen", cmpl_valid_o, 1'b1);
    at_cyc = cyc;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || busy_o || queue_level_o != 3'd0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("drain", (exp_q.size() == 0) && !busy_o && (queue_level_o == 3'd0), 1'b1);
  endtask

  task automatic check_reset_outputs();
    check("rst_start", start_o, 1'b0);
    check("rst_push_ready", push_ready_o, 1'b1);
    check("rst_cmpl_valid", cmpl_valid_o, 1'b0);
    check("rst_cmpl_id", cmpl_id_o, 4'd0);
    check("rst_cmpl_status", cmpl_status_o, 2'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_level", queue_level_o, 3'd0);
    check("rst_push_id", push_id_o, 4'd0);
    check("rst_desc", dut_desc, 96'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int s_cyc, c_cyc;
    logic [3:0] hold_id;
    logic [1:0] hold_status;

    reset = 1'b1;
    push_valid_i = 1'b0;
    push_a_addr_i = '0; push_b_addr_i = '0; push_c_addr_i = '0;
    push_m_i = '0; push_n_i = '0; push_p_i = '0;
    cmpl_ready_i = 1'b1;
    model_id = 4'd0;
    done_en = 1'b1;
    done_delay = 20;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;

    // Single job: exact launch latency and one-cycle start.
    push_job(16'h0000, 16'h0100, 16'h0200, 16'd16, 16'd16, 16'd16, 1'b0);
    check("lvl_after_push", queue_level_o, 3'd1);
    check("start_before_pop", start_o, 1'b0);
    @(negedge clk);
    check("start_after_pop", start_o, 1'b1);
    check("busy_launch", busy_o, 1'b1);
    check("lvl_after_pop", queue_level_o, 3'd0);
    @(negedge clk);
    check("start_one_cycle", start_o, 1'b0);
    drain();

    // Fill the FIFO while a long job runs.
    done_delay = 60;
    push_job(16'h1000, 16'h1100, 16'h1200, 16'd8, 16'd4, 16'd2, 1'b0);
    wait_start(s_cyc);
    for (int i = 0; i < 4; i++)
      push_job(16'(16'h2000 + i), 16'(16'h3000 + i), 16'(16'h4000 + i), 16'(i + 1), 16'(i + 2), 16'(i + 3), 1'b0);
    check("full_level", queue_level_o, 3'd4);
    check("full_not_ready", push_ready_o, 1'b0);
    check("full_busy", busy_o, 1'b1);
    done_delay = 3;
    drain();

    // Zero dimension: no launch, BAD_DIM status.
    push_job(16'h5000, 16'h5100, 16'h5200, 16'd4, 16'd0, 16'd4, 1'b0);
    @(negedge clk);
    check("bad_dim_valid", cmpl_valid_o, 1'b1);
    check("bad_dim_no_start", start_o, 1'b0);
    check("bad_dim_status", cmpl_status_o, 2'd1);
    drain();

    // ID wrap: the 17th accepted job gets ID 0.
    done_delay = 2;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) check("id_wrap", push_id_o, 4'd0);
      push_job(16'(16'h6000 + i), 16'(16'h7000 + i), 16'(16'h8000 + i), 16'(i + 1), 16'd3, 16'(10 - i), 1'b0);
    end
    drain();

    // Back-pressure on the completion port.
    cmpl_ready_i = 1'b0;
    done_delay = 4;
    push_job(16'h9000, 16'h9100, 16'h9200, 16'd2, 16'd2, 16'd2, 1'b0);
    push_job(16'hA000, 16'hA100, 16'hA200, 16'd3, 16'd3, 16'd3, 1'b0);
    wait_cmpl(c_cyc);
    hold_id = cmpl_id_o;
    hold_status = cmpl_status_o;
    check("hold_first_id", hold_id, exp_q[0].id);
    repeat (10) begin
      @(negedge clk);
      check("hold_stable", {cmpl_valid_o, cmpl_id_o, cmpl_status_o, start_o}, {1'b1, hold_id, hold_status, 1'b0});
    end
    check("hold_queued", queue_level_o, 3'd1);
    @(posedge clk);
    #1 cmpl_ready_i = 1'b1;
    drain();

    // Reset during RUN drops in-flight and queued jobs.
    done_en = 1'b0;
    push_job(16'hB000, 16'hB100, 16'hB200, 16'd5, 16'd5, 16'd5, 1'b0);
    wait_start(s_cyc);
    push_job(16'hC000, 16'hC100, 16'hC200, 16'd6, 16'd6, 16'd6, 1'b0);
    repeat (3) @(negedge clk);
    check("run_busy", busy_o, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    model_id = 4'd0;
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("post_reset_quiet", {cmpl_valid_o, start_o, busy_o}, 3'b000);
    end

`ifdef MATMUL_JOB_TIMEOUT_EN
    // Watchdog: no done, TIMEOUT after TO RUN cycles.
    push_job(16'hD000, 16'hD100, 16'hD200, 16'd7, 16'd7, 16'd7, 1'b1);
    wait_start(s_cyc);
    wait_cmpl(c_cyc);
    check("timeout_latency", 32'(c_cyc - s_cyc), 32'(TO + 1));
    check("timeout_status", cmpl_status_o, 2'd2);
    drain();
`endif
    done_en = 1'b1;

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
